multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control sequencer for the 9-bit accumulator-style core, succeeding the single-cycle opcode decoder. It fetches an instruction over a ready/request memory handshake, latches it, decodes the 4-bit opcode, and steps through EXEC/MEM/WB states. Each state drives the ALU op, register write, PC and memory strobes. It also adds halt/resume, illegal-opcode and memory-timeout faults, and a retired-instruction counter.

## Interface
- INSTR_W, 9, instruction width; opcode = ir[INSTR_W-1 -: 4], imm_flag = ir[INSTR_W-5]; must be ≥ 5
- TIMEOUT, 16, max cycles of mem_req without mem_ready before FAULT; 0 disables timeout
- CNT_W, 16, width of retired counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  leave IDLE or HALT and begin fetching
- instr_data  in  INSTR_W  instruction from instruction memory, valid with mem_ready in FETCH
- mem_ready  in  1  memory completes the current request this cycle
- alu_cond  in  1  branch-condition result from ALU, valid in EXEC
- mem_req  out  1  memory request (FETCH, MEM)
- mem_we  out  1  store strobe, only with mem_req in MEM for STR
- alu_inst  out  4  ALU op; ADD 0, SUB 1, SFL 2, SFR 3, INC 4, DEC 5, BNE 6, BEQ 7, BLT 8
- write_flag  out  1  register-file write enable
- pc_inc  out  1  PC+1 pulse
- pc_branch  out  1  load branch target
- pc_jump  out  1  load jump target
- halted  out  1  in HALT
- fault  out  1  in FAULT (sticky)
- retired  out  CNT_W  completed-instruction count, saturating

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT. Reset → IDLE.
- IDLE: all outputs 0. start → FETCH.
- FETCH: mem_req=1, mem_we=0. On mem_ready: latch instr_data into IR, pulse pc_inc, go to DECODE.
- DECODE: route by opcode; no strobes.
  - HALT (1110) → HALT.
  - TBA (1111) → FAULT.
  - LB (0000), LHB (0001), STR (0011) → MEM.
  - LIM (0100), MVB (0101), MVF (0110) → WB.
  - ADD (0111), SUB (1000), SFT (1001), BNE (1010), BEQ (1011), BLT (1100), INC (1101), JMP (0010) → EXEC.
- EXEC: alu_inst is driven from opcode.
  - SFT: imm=1 → SFR, imm=0 → SFL.
  - INC: imm=1 → INC, imm=0 → DEC.
  - Branches: pc_branch = alu_cond, then → FETCH.
  - JMP: pc_jump=1, alu_inst=0, then → FETCH.
  - All other EXEC ops → WB.
- MEM: mem_req=1, mem_we = (opcode==STR). On mem_ready: LB/LHB → WB, STR → FETCH.
- WB: write_flag=1 for exactly one cycle, then → FETCH.
- HALT: halted=1. start → FETCH (resumes at current PC).
- FAULT: fault=1. Exited only by rst_n.
- alu_inst = 0 in every state except EXEC.
- start is ignored outside IDLE and HALT.
- retired increments by 1 on each completion, and holds at all-ones:
  - WB→FETCH
  - EXEC→FETCH (branch or JMP)
  - MEM→FETCH (STR)
  - DECODE→HALT
- Timeout: a wait counter clears on entry to FETCH or MEM and counts cycles with mem_req=1 and mem_ready=0.
  - When TIMEOUT≠0 and the count reaches TIMEOUT-1 with mem_ready=0, the next state is FAULT.
  - mem_ready in that same cycle wins; no fault.

## Timing
- State, IR, wait counter and retired are registered.
- mem_req, mem_we, halted, fault and alu_inst are decoded from state/IR (Moore).
- pc_inc, pc_branch and ir-latch are Mealy on mem_ready/alu_cond within the cycle.
- Zero-wait memory (mem_ready high in the first cycle) gives these latencies:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LIM/MVB/MVF: 3 cycles.
  - LB/LHB: 4 cycles.
  - STR: 3 cycles.
  - Branch/JMP: 3 cycles.
  - HALT: 2 cycles to halted=1.
- Each memory wait cycle adds 1 cycle.
- Asynchronous rst_n low at any point:
  - Immediately: IDLE, all outputs 0, retired=0, IR=0.
  - In-flight mem_req drops asynchronously.

## Test plan
- Reset, start, ADD (0111_x_xxxx) with mem_ready tied 1:
  - pc_inc at cycle 1.
  - alu_inst=0 in EXEC at cycle 3.
  - write_flag=1 only at cycle 4.
  - retired=1.
- SFT imm=1 then INC imm=0 → alu_inst 3 then 5 in their EXEC cycles. BNE with alu_cond=1 → pc_branch=1 for one cycle, no write_flag.
- STR with mem_ready delayed 3 cycles in MEM → mem_req=mem_we=1 for 4 cycles, then FETCH; retired +1; no write_flag. LB → write_flag in the cycle after mem_ready.
- TIMEOUT=4, mem_ready held 0 in FETCH:
  - mem_req high for 4 cycles, then fault=1 permanently; start ignored.
  - Repeat with mem_ready on the 4th cycle → no fault.
- HALT (1110) → halted=1 after DECODE. Pulse start → FETCH resumes. TBA (1111) → fault=1.
- Assert rst_n low during MEM: mem_req drops without a clock edge, retired=0. Run 2^CNT_W+2 instructions with CNT_W=4 → retired saturates at 15.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer for the 9-bit accumulator core: fetch over a
// ready/request handshake, decode, then EXEC/MEM/WB with halt, fault and retire count.
module multicycle_control #(
  parameter int INSTR_W = 9,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               mem_ready,
  input  logic               alu_cond,
  output logic               mem_req,
  output logic               mem_we,
  output logic [3:0]         alu_inst,
  output logic               write_flag,
  output logic               pc_inc,
  output logic               pc_branch,
  output logic               pc_jump,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam logic [3:0] OP_LB  = 4'd0,  OP_LHB = 4'd1,  OP_JMP = 4'd2,  OP_STR = 4'd3;
  localparam logic [3:0] OP_LIM = 4'd4,  OP_MVB = 4'd5,  OP_MVF = 4'd6,  OP_ADD = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8,  OP_SFT = 4'd9,  OP_BNE = 4'd10, OP_BEQ = 4'd11;
  localparam logic [3:0] OP_BLT = 4'd12, OP_INC = 4'd13, OP_HLT = 4'd14, OP_TBA = 4'd15;

  // Wait counter only needs to reach TIMEOUT-1 before the fault fires.
  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [3:0] opcode;
  logic       imm;
  logic       is_branch;
  logic       timeout_hit;
  logic       retire;

  assign opcode    = ir_q[INSTR_W-1 -: 4];
  assign imm       = ir_q[INSTR_W-5];
  assign is_branch = (opcode == OP_BNE) || (opcode == OP_BEQ) || (opcode == OP_BLT);

  generate
    if (INSTR_W > 5) begin : g_ir_low
      logic unused_ir_low;
      assign unused_ir_low = ^ir_q[INSTR_W-6:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    retire      = 1'b0;
    timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST) && !mem_ready;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = instr_data;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        unique case (opcode)
          OP_HLT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          OP_TBA:                 state_d = S_FAULT;
          OP_LB, OP_LHB, OP_STR:  state_d = S_MEM;
          OP_LIM, OP_MVB, OP_MVF: state_d = S_WB;
          default:                state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (is_branch || opcode == OP_JMP) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_STR) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:   if (start) state_d = S_FETCH;
      default:  state_d = S_FAULT;
    endcase

    // Any state change (including entry to FETCH/MEM) restarts the wait count.
    if (state_d != state_q)          wait_d = '0;
    else if (mem_req && !mem_ready)  wait_d = wait_q + 1'b1;
    else                             wait_d = wait_q;

    retired_d = (retire && (retired_q != {CNT_W{1'b1}})) ? retired_q + 1'b1 : retired_q;
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    alu_inst   = 4'd0;
    write_flag = 1'b0;
    pc_inc     = 1'b0;
    pc_branch  = 1'b0;
    pc_jump    = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        pc_inc  = mem_ready;
      end
      S_EXEC: begin
        unique case (opcode)
          OP_SUB:  alu_inst = 4'd1;
          OP_SFT:  alu_inst = imm ? 4'd3 : 4'd2;
          OP_INC:  alu_inst = imm ? 4'd4 : 4'd5;
          OP_BNE:  alu_inst = 4'd6;
          OP_BEQ:  alu_inst = 4'd7;
          OP_BLT:  alu_inst = 4'd8;
          default: alu_inst = 4'd0;
        endcase
        pc_branch = is_branch && alu_cond;
        pc_jump   = (opcode == OP_JMP);
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STR);
      end
      S_WB:    write_flag = 1'b1;
      S_HALT:  halted = 1'b1;
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction vector table plus
// hand-written sequences for wait states, timeout, halt, fault and async reset.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [8:0] instr_data;
  logic       mem_ready;
  logic       alu_cond;
  logic       mem_req, mem_we, write_flag, pc_inc, pc_branch, pc_jump, halted, fault;
  logic [3:0] alu_inst;
  logic [3:0] retired;

  int total = 0;
  int bad   = 0;

  multicycle_control #(.INSTR_W(9), .TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_data(instr_data),
    .mem_ready(mem_ready), .alu_cond(alu_cond), .mem_req(mem_req), .mem_we(mem_we),
    .alu_inst(alu_inst), .write_flag(write_flag), .pc_inc(pc_inc),
    .pc_branch(pc_branch), .pc_jump(pc_jump), .halted(halted), .fault(fault),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] instr;
    logic       cond;
    int         cyc;
    int         alu3;
    int         wf;
    int         br;
    int         jp;
    int         we;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic [3:0] op, input logic imm, input logic cond,
                              input int cyc, input int alu3, input int wf,
                              input int br, input int jp, input int we);
    vec_t v;
    v.instr = {op, imm, 4'b0000};
    v.cond  = cond;
    v.cyc   = cyc;
    v.alu3  = alu3;
    v.wf    = wf;
    v.br    = br;
    v.jp    = jp;
    v.we    = we;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    start      = 1'b0;
    mem_ready  = 1'b0;
    alu_cond   = 1'b0;
    instr_data = '0;
    #1;
    check("reset_outputs",
          int'({mem_req, mem_we, alu_inst, write_flag, pc_inc, pc_branch, pc_jump, halted, fault}), 0);
    check("reset_retired", int'(retired), 0);
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Runs one instruction from FETCH (zero-wait memory) until the next FETCH completes.
  task automatic run_instr(input logic [8:0] instr, input logic cond,
                           output int cyc, output int alu3, output int wf, output int wfc,
                           output int br, output int jp, output int we, output int inc1);
    int c;
    c = 1; cyc = 0; alu3 = -1; wf = 0; wfc = 0; br = 0; jp = 0; we = 0; inc1 = 0;
    while (c <= 12) begin
      instr_data = instr;
      mem_ready  = 1'b1;
      alu_cond   = cond;
      #1;
      if (c > 1 && pc_inc) begin
        cyc = c - 1;
        return;
      end
      if (c == 1) inc1 = int'(pc_inc);
      if (c == 3) alu3 = int'(alu_inst);
      if (write_flag) begin
        wf++;
        wfc = c;
      end
      br += int'(pc_branch);
      jp += int'(pc_jump);
      we += int'(mem_we);
      tick;
      c++;
    end
    cyc = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, alu3, wf, wfc, br, jp, we, inc1;
    int exp_ret;

    tbl[0]  = mk(4'b0111, 1'b0, 1'b1, 4, 0, 1, 0, 0, 0);
    tbl[1]  = mk(4'b1000, 1'b0, 1'b0, 4, 1, 1, 0, 0, 0);
    tbl[2]  = mk(4'b1001, 1'b1, 1'b0, 4, 3, 1, 0, 0, 0);
    tbl[3]  = mk(4'b1101, 1'b0, 1'b1, 4, 5, 1, 0, 0, 0);
    tbl[4]  = mk(4'b1001, 1'b0, 1'b0, 4, 2, 1, 0, 0, 0);
    tbl[5]  = mk(4'b1101, 1'b1, 1'b0, 4, 4, 1, 0, 0, 0);
    tbl[6]  = mk(4'b1010, 1'b0, 1'b1, 3, 6, 0, 1, 0, 0);
    tbl[7]  = mk(4'b1011, 1'b0, 1'b0, 3, 7, 0, 0, 0, 0);
    tbl[8]  = mk(4'b1100, 1'b0, 1'b1, 3, 8, 0, 1, 0, 0);
    tbl[9]  = mk(4'b0010, 1'b0, 1'b1, 3, 0, 0, 0, 1, 0);
    tbl[10] = mk(4'b0100, 1'b0, 1'b1, 3, 0, 1, 0, 0, 0);
    tbl[11] = mk(4'b0101, 1'b0, 1'b0, 3, 0, 1, 0, 0, 0);
    tbl[12] = mk(4'b0110, 1'b0, 1'b0, 3, 0, 1, 0, 0, 0);
    tbl[13] = mk(4'b0000, 1'b0, 1'b0, 4, 0, 1, 0, 0, 0);
    tbl[14] = mk(4'b0001, 1'b0, 1'b0, 4, 0, 1, 0, 0, 0);
    tbl[15] = mk(4'b0011, 1'b0, 1'b0, 3, 0, 0, 0, 0, 1);
    tbl[16] = mk(4'b0111, 1'b1, 1'b0, 4, 0, 1, 0, 0, 0);
    tbl[17] = mk(4'b1011, 1'b0, 1'b1, 3, 7, 0, 1, 0, 0);

    do_reset;
    check("idle_mem_req", int'(mem_req), 0);
    do_start;
    #1;
    check("fetch_after_start", int'(mem_req), 1);

    for (int i = 0; i < 18; i++) begin
      run_instr(tbl[i].instr, tbl[i].cond, cyc, alu3, wf, wfc, br, jp, we, inc1);
      check($sformatf("v%0d_cycles", i), cyc, tbl[i].cyc);
      check($sformatf("v%0d_pc_inc1", i), inc1, 1);
      check($sformatf("v%0d_alu_c3", i), alu3, tbl[i].alu3);
      check($sformatf("v%0d_write_flag", i), wf, tbl[i].wf);
      if (tbl[i].wf != 0) check($sformatf("v%0d_wf_cycle", i), wfc, tbl[i].cyc);
      check($sformatf("v%0d_pc_branch", i), br, tbl[i].br);
      check($sformatf("v%0d_pc_jump", i), jp, tbl[i].jp);
      check($sformatf("v%0d_mem_we", i), we, tbl[i].we);
      exp_ret = (i + 1 > 15) ? 15 : i + 1;
      check($sformatf("v%0d_retired", i), int'(retired), exp_ret);
    end

    // STR with three memory wait cycles, then LB with one.
    do_reset;
    do_start;
    instr_data = 9'b0011_0_0000;
    mem_ready  = 1'b1;
    tick;
    mem_ready = 1'b0;
    #1;
    check("str_decode_req", int'(mem_req), 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      check($sformatf("str_mem%0d_req_we", i), int'({mem_req, mem_we}), 3);
      check($sformatf("str_mem%0d_wf", i), int'(write_flag), 0);
      tick;
    end
    mem_ready = 1'b0;
    #1;
    check("str_back_fetch", int'({mem_req, mem_we}), 2);
    check("str_retired", int'(retired), 1);
    check("str_no_fault", int'(fault), 0);
    instr_data = 9'b0000_0_0000;
    mem_ready  = 1'b1;
    tick;
    tick;
    mem_ready = 1'b0;
    #1;
    check("lb_mem_wait_wf", int'(write_flag), 0);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    #1;
    check("lb_wb_wf", int'(write_flag), 1);
    tick;
    check("lb_retired", int'(retired), 2);

    // Fetch timeout: no mem_ready for TIMEOUT cycles.
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("to_fetch%0d_req", i), int'(mem_req), 1);
      check($sformatf("to_fetch%0d_fault", i), int'(fault), 0);
      tick;
    end
    check("to_fault", int'(fault), 1);
    check("to_req_drop", int'(mem_req), 0);
    start = 1'b1;
    tick;
    tick;
    start = 1'b0;
    check("to_fault_sticky", int'({fault, mem_req}), 2);

    // mem_ready on the last allowed cycle wins; then HALT, resume, TBA.
    do_reset;
    do_start;
    instr_data = 9'b1110_0_0000;
    for (int i = 0; i < 3; i++) tick;
    mem_ready = 1'b1;
    #1;
    check("late_ready_pc_inc", int'(pc_inc), 1);
    check("late_ready_no_fault", int'(fault), 0);
    tick;
    mem_ready = 1'b0;
    check("halt_decode", int'({halted, mem_req, fault}), 0);
    tick;
    check("halt_halted", int'(halted), 1);
    check("halt_retired", int'(retired), 1);
    tick;
    check("halt_holds", int'({halted, mem_req}), 2);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("resume_fetch", int'({halted, mem_req}), 1);
    instr_data = 9'b1111_0_0000;
    mem_ready  = 1'b1;
    tick;
    mem_ready = 1'b0;
    tick;
    check("tba_fault", int'(fault), 1);

    // Asynchronous reset while a MEM request is outstanding.
    do_reset;
    do_start;
    run_instr(9'b0111_0_0000, 1'b0, cyc, alu3, wf, wfc, br, jp, we, inc1);
    instr_data = 9'b0000_0_0000;
    mem_ready  = 1'b1;
    tick;
    mem_ready = 1'b0;
    tick;
    #1;
    check("mem_req_before_rst", int'(mem_req), 1);
    check("retired_before_rst", int'(retired), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", int'(mem_req), 0);
    check("async_rst_retired", int'(retired), 0);
    tick;
    rst_n = 1'b1;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
